// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and opcode classification shared by the sequencer and its bench.
package alu_seq_pkg;
  localparam logic [2:0] OP_ID  = 3'b000;
  localparam logic [2:0] OP_INC = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NEG = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
  function automatic logic is_single(input logic [2:0] op);
    return op == OP_ID || op == OP_INC || op == OP_ADD || op == OP_NEG;
  endfunction
endpackage

// File: rtl/alu_seq_cmdbuf.sv
// alu_seq_cmdbuf: 2-entry command FIFO; push and pop may coincide.
module alu_seq_cmdbuf #(
  parameter int DW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  logic [1:0][DW-1:0] mem_q, mem_d;
  logic wr_q, wr_d, rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = push ? ~wr_q : wr_q;
    rd_d = pop ? ~rd_q : rd_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk)
    if (rst) begin
      mem_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  assign dout = mem_q[rd_q];
  assign full = cnt_q == 2'd2;
  assign empty = cnt_q == 2'd0;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-driven ALU controller with shift-add MUL; ALU_SEQ_CMDBUF_EN adds a 2-entry command FIFO.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  output logic [2:0]         alu_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_s,
  input  logic               alu_c,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic               res_cout,
  output logic               res_err
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state_q, state_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2*WIDTH-1:0] res_data_q, res_data_d, step;
  logic res_cout_q, res_cout_d, res_err_q, res_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic in_valid, take;
  logic [2:0] in_op;
  logic [WIDTH-1:0] in_a, in_b;
  assign take = state_q == IDLE && in_valid;
`ifdef ALU_SEQ_CMDBUF_EN
  logic full, empty;
  alu_seq_cmdbuf #(.DW(3 + 2*WIDTH)) u_cmdbuf (
    .clk  (clk),
    .rst  (reset),
    .push (cmd_valid && !full),
    .din  ({cmd_op, cmd_a, cmd_b}),
    .pop  (take),
    .dout ({in_op, in_a, in_b}),
    .full (full),
    .empty(empty)
  );
  assign cmd_ready = !full;
  assign in_valid = !empty;
`else
  assign cmd_ready = state_q == IDLE;
  assign in_valid = cmd_valid;
  assign {in_op, in_a, in_b} = {cmd_op, cmd_a, cmd_b};
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      alu_op_q <= OP_ID;
      alu_a_q <= '0;
      alu_b_q <= '0;
      res_data_q <= '0;
      res_cout_q <= 1'b0;
      res_err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      alu_op_q <= alu_op_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      res_data_q <= res_data_d;
      res_cout_q <= res_cout_d;
      res_err_q <= res_err_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (take) state_d = in_op == OP_MUL ? MUL : is_single(in_op) ? EXEC : DONE;
      EXEC: state_d = DONE;
      MUL:  if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // During MUL res_data_q doubles as the {hi,lo} shift register; alu_a tracks the next hi.
  always_comb begin
    step = res_data_q[0] ? {alu_c, alu_s, res_data_q[WIDTH-1:1]} : {1'b0, res_data_q[2*WIDTH-1:1]};
    alu_op_d = OP_ID;
    alu_a_d = '0;
    alu_b_d = '0;
    res_data_d = res_data_q;
    res_cout_d = res_cout_q;
    res_err_d = res_err_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (take) begin
        res_cout_d = 1'b0;
        res_err_d = !is_single(in_op) && in_op != OP_MUL;
        if (in_op == OP_MUL) begin
          alu_op_d = OP_ADD;
          alu_b_d = in_a;
          res_data_d = {{WIDTH{1'b0}}, in_b};
          cnt_d = '0;
        end else if (is_single(in_op)) begin
          alu_op_d = in_op;
          alu_a_d = in_a;
          alu_b_d = in_b;
        end else res_data_d = '0;
      end
      EXEC: begin
        res_data_d = {{WIDTH{1'b0}}, alu_s};
        res_cout_d = alu_c;
      end
      MUL: begin
        alu_op_d = cnt_q == CW'(WIDTH - 1) ? OP_ID : OP_ADD;
        alu_a_d = cnt_q == CW'(WIDTH - 1) ? '0 : step[2*WIDTH-1:WIDTH];
        alu_b_d = cnt_q == CW'(WIDTH - 1) ? '0 : alu_b_q;
        res_data_d = step;
        cnt_d = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end
  assign res_valid = state_q == DONE;
  assign alu_op = alu_op_q;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign res_data = res_data_q;
  assign res_cout = res_cout_q;
  assign res_err = res_err_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random and directed checks of alu_sequencer against an arithmetic reference model.
module tb_alu_sequencer;
  import alu_seq_pkg::*;
  localparam int W = 4;
`ifdef ALU_SEQ_CMDBUF_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, res_ready = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [W-1:0] cmd_a = '0, cmd_b = '0;
  logic cmd_ready, alu_c, res_valid, res_cout, res_err;
  logic [2:0] alu_op;
  logic [W-1:0] alu_a, alu_b, alu_s;
  logic [2*W-1:0] res_data;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cout(res_cout), .res_err(res_err)
  );
  // Datapath stand-in: operand preprocess plus adder, carry out of the W-bit add.
  always_comb begin
    {alu_c, alu_s} = {1'b0, alu_a};
    case (alu_op)
      3'b001: {alu_c, alu_s} = {1'b0, alu_a} + (W+1)'(1);
      3'b010: {alu_c, alu_s} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b100: {alu_c, alu_s} = {1'b0, ~alu_a} + (W+1)'(1);
      default: ;
    endcase
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [2:0] op, input int a, input int b,
                                output int d, output int c, output int e, output int lat);
    int r;
    d = 0; c = 0; e = 0; lat = 2 + EXTRA; r = 0;
    case (op)
      OP_ID:  r = a;
      OP_INC: r = a + 1;
      OP_ADD: r = a + b;
      OP_NEG: r = (1 << W) - a;
      default: ;
    endcase
    if (op == OP_MUL) begin
      d = a * b;
      lat = W + 1 + EXTRA;
    end else if (op == OP_ID || op == OP_INC || op == OP_ADD || op == OP_NEG) begin
      d = r % (1 << W);
      c = int'(r >= (1 << W));
    end else begin
      e = 1;
      lat = 1 + EXTRA;
    end
  endfunction
  task automatic do_op(input logic [2:0] op, input int a, input int b, input int hold, input string tag);
    int d, c, e, lat, n, guard;
    logic rdy_seen, op_seen;
    logic [2*W-1:0] d0;
    model(op, a, b, d, c, e, lat);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = W'(a); cmd_b = W'(b);
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check({tag, "_accept"}, 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0; rdy_seen = 1'b0; op_seen = 1'b0;
    do begin
      @(negedge clk);
      n++;
      rdy_seen |= cmd_ready;
      op_seen |= alu_op != 3'b000;
    end while (!res_valid && n < 40);
    check({tag, "_lat"}, n, lat);
    check({tag, "_data"}, res_data, d);
    check({tag, "_cout"}, res_cout, c);
    check({tag, "_err"}, res_err, e);
    if (EXTRA == 0) check({tag, "_busy"}, rdy_seen, 0);
    if (e != 0) check({tag, "_aluop"}, op_seen, 0);
    d0 = res_data;
    repeat (hold) begin
      @(negedge clk);
      check({tag, "_hold"}, {res_valid, res_data, cmd_ready}, {1'b1, d0, 1'(EXTRA)});
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drop"}, res_valid, 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [2:0] ops [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b111, 3'b111, 3'b011, 3'b110};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", res_valid, 0);
    check("rst_out", {res_data, res_cout, res_err}, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_alu", {alu_op, alu_a, alu_b}, 0);
    do_op(OP_ADD, 3, 4, 0, "add_3_4");
    do_op(OP_ADD, 9, 9, 0, "add_9_9");
    do_op(OP_NEG, 3, 0, 0, "neg_3");
    do_op(OP_INC, 15, 0, 0, "inc_15");
    do_op(OP_MUL, 15, 15, 0, "mul_15_15");
    do_op(OP_MUL, 7, 0, 0, "mul_7_0");
    do_op(OP_MUL, 0, 9, 0, "mul_0_9");
    do_op(3'b011, 5, 6, 0, "illegal");
    do_op(OP_ADD, 5, 6, 10, "stall");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_MUL; cmd_a = 4'd15; cmd_b = 4'd15;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2 + EXTRA) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", cmd_ready, 1);
    repeat (6) begin
      check("midrst_valid", res_valid, 0);
      @(negedge clk);
    end
    do_op(OP_ADD, 1, 1, 0, "post_rst");
    for (int i = 0; i < 60; i++)
      do_op(ops[$urandom_range(0, 7)], int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), "rand");
`ifdef ALU_SEQ_CMDBUF_EN
    begin
      logic [2:0] bop [3] = '{OP_ADD, OP_MUL, OP_INC};
      int ba [3] = '{3, 5, 15};
      int bb [3] = '{4, 3, 0};
      int d, c, e, lat, n;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = bop[k]; cmd_a = W'(ba[k]); cmd_b = W'(bb[k]);
        n = 0;
        while (!cmd_ready && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
      end
      @(negedge clk);
      check("buf_full", cmd_ready, 0);
      for (int k = 0; k < 3; k++) begin
        model(bop[k], ba[k], bb[k], d, c, e, lat);
        n = 0;
        while (!res_valid && n < 40) begin
          @(negedge clk);
          n++;
        end
        check("buf_order", {res_valid, res_data, res_cout}, {1'b1, 8'(d), 1'(c)});
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
      end
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
